tuart_tx: RTL

Tiny-UART transmitter for the SUMP protocol: serialises a multi-word response (ID, metadata, sample data) from the LogIP core onto the UART tx line. Each word is framed as 1 start bit, WORD_BITS data bits (LSB first) and 1 stop bit, with no parity. Words go out lowest word first and back to back. It is the counterpart of the Tiny-UART receiver and shares its bit-time parameterisation, so a loopback pair runs at the same rate.

---
 rtl/tuart_pkg.sv | 17 +
 rtl/tuart_tx_if.sv | 33 +++
 rtl/tuart_bitclk.sv | 34 +++
 rtl/tuart_tx.sv | 129 ++++++++++++
 4 files changed

// File: rtl/tuart_pkg.sv
// Shared definitions for the Tiny-UART transmitter and receiver.
//   tx_states_t        : transmitter FSM state encoding
//   DEF_WORD_BITS      : default data bits per UART word
//   DEF_CLK_PER_SAMPLE : default clock cycles per UART bit
package tuart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'b00,
    TX_START = 2'b01,
    TX_DATA  = 2'b10,
    TX_STOP  = 2'b11
  } tx_states_t;

  localparam int unsigned DEF_WORD_BITS      = 8;
  localparam int unsigned DEF_CLK_PER_SAMPLE = 4;

endpackage

// File: rtl/tuart_tx_if.sv
// Request/status bundle between the LogIP core and the Tiny-UART transmitter.
//   data  : payload, word k at data[k*WORD_BITS +: WORD_BITS]
//   words : number of words to send (1..TX_WORDS, larger values clamp)
//   stb   : start request, honoured only while idle
//   tx    : UART tx line, idle high
//   busy  : transfer in progress
//   done  : one-cycle pulse after the last stop bit
// master = requester side, slave = transmitter side.
interface tuart_tx_if
  import tuart_pkg::*;
#(
  parameter int unsigned WORD_BITS = DEF_WORD_BITS,
  parameter int unsigned TX_WORDS  = 4
);

  logic [WORD_BITS*TX_WORDS-1:0]   data;
  logic [$clog2(TX_WORDS+1)-1:0]   words;
  logic                            stb;
  logic                            tx;
  logic                            busy;
  logic                            done;

  modport master (
    output data, words, stb,
    input  tx, busy, done
  );

  modport slave (
    input  data, words, stb,
    output tx, busy, done
  );

endinterface

// File: rtl/tuart_bitclk.sv
// Bit-time tick generator.
//   clk_i  : system clock
//   rst_i  : asynchronous reset, active-high
//   clr_i  : restart the count from zero
//   tick_o : one-cycle pulse on the last cycle of every CLK_PER_SAMPLE-cycle bit
module tuart_bitclk
  import tuart_pkg::*;
#(
  parameter int unsigned CLK_PER_SAMPLE = DEF_CLK_PER_SAMPLE
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = $clog2(CLK_PER_SAMPLE + 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = (cnt_q == CNT_W'(CLK_PER_SAMPLE - 1));

  // Counter returns to zero on every tick, so it never wraps mid-bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tuart_tx.sv
// Tiny-UART transmitter: sends 1..TX_WORDS words, lowest first, each framed
// as start bit, WORD_BITS data bits LSB first, stop bit, with no gap between
// words.
//   clk_i : system clock
//   rst_i : asynchronous reset, active-high (forces tx high at once)
//   bus   : slave side of tuart_tx_if (data/words/stb in, tx/busy/done out)
module tuart_tx
  import tuart_pkg::*;
#(
  parameter int unsigned WORD_BITS      = DEF_WORD_BITS,
  parameter int unsigned TX_WORDS       = 4,
  parameter int unsigned CLK_PER_SAMPLE = DEF_CLK_PER_SAMPLE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tuart_tx_if.slave   bus
);

  localparam int unsigned DATA_W = WORD_BITS * TX_WORDS;
  localparam int unsigned WC_W   = $clog2(TX_WORDS + 1);
  localparam int unsigned BIT_W  = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned IDX_W  = (TX_WORDS > 1) ? $clog2(TX_WORDS) : 1;

  tx_states_t          state_q, state_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [WC_W-1:0]     wcnt_q, wcnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic [WORD_BITS-1:0] cur_word;
  logic                tick;
  logic                clr;

  tuart_bitclk #(
    .CLK_PER_SAMPLE (CLK_PER_SAMPLE)
  ) u_bitclk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr),
    .tick_o (tick)
  );

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != TX_IDLE);
  assign bus.done = done_q;

  assign cur_word = buf_q[idx_q*WORD_BITS +: WORD_BITS];

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bit_d   = bit_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clr     = 1'b0;
    tx_d    = 1'b1;

    unique case (state_q)
      TX_IDLE: begin
        // Hold the bit timer at zero so START gets a full bit time.
        clr = 1'b1;
        if (bus.stb && (bus.words != '0)) begin
          buf_d   = bus.data;
          wcnt_d  = (bus.words > WC_W'(TX_WORDS)) ? WC_W'(TX_WORDS) : bus.words;
          bit_d   = '0;
          idx_d   = '0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) state_d = TX_DATA;
      end
      TX_DATA: begin
        if (tick) begin
          buf_d[idx_q*WORD_BITS +: WORD_BITS] = cur_word >> 1;
          if (bit_q == BIT_W'(WORD_BITS - 1)) begin
            bit_d   = '0;
            state_d = TX_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          wcnt_d = wcnt_q - WC_W'(1);
          if (wcnt_q > WC_W'(1)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // tx is registered, so it is derived from the state being entered.
    unique case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = buf_d[idx_d*WORD_BITS];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TX_IDLE;
      buf_q   <= '0;
      bit_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      bit_q   <= bit_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule
